// File: rtl/mmio_fifo_pkg.sv
// Shared definitions for the MMIO push/pop FIFO: data width, status-word
// bit positions and the MMIO word type.
package mmio_fifo_pkg;

   localparam int MMIO_DATA_W = 64;

   // Bit positions inside the 64-bit status word
   localparam int ST_EMPTY     = 0;
   localparam int ST_FULL      = 1;
   localparam int ST_UDF       = 2;
   localparam int ST_OVF       = 3;
   localparam int ST_COUNT_LSB = 16;
   localparam int ST_HWM_LSB   = 32;
   localparam int ST_DROPS_LSB = 48;

   typedef logic [63:0] t_mmio_word;

   // True when v is a power of two no smaller than 2
   function automatic bit is_pow2_min2(input int v);
      return (v >= 2) && ((v & (v - 1)) == 0);
   endfunction

endpackage

// File: rtl/mmio_fifo_ram.sv
// Simple dual-port storage for the MMIO FIFO: one write port, one registered
// read port. The array has no reset; a read and write to the same address in
// one cycle returns the old contents (read-first), which lets a full FIFO
// accept a push into the slot being popped.
module mmio_fifo_ram
   import mmio_fifo_pkg::*;
#(
   parameter int WIDTH = MMIO_DATA_W,
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_reg [0:DEPTH-1];
   logic [WIDTH-1:0] rdata_reg;

   // Write port
   always_ff @(posedge clk) begin
      if (we) begin
         mem_reg[waddr] <= wdata;
      end
   end

   // Registered read port, only updates on an accepted pop
   always_ff @(posedge clk) begin
      if (re) begin
         rdata_reg <= mem_reg[raddr];
      end
   end

   assign rdata = rdata_reg;

endmodule

// File: rtl/mmio_fifo_buf.sv
// Circular-buffer FIFO between the MMIO write decode (producer) and the MMIO
// read responder (consumer). Every pop request gets a response one cycle
// later; popping an empty FIFO answers with data 0 and rd_err set.
// Optional feature: define MMIO_FIFO_STATS_EN to add a high-water mark and a
// saturating dropped-push counter, exported in status[63:32].
module mmio_fifo_buf
   import mmio_fifo_pkg::*;
#(
   parameter int WIDTH    = MMIO_DATA_W,
   parameter int DEPTH    = 8,
   parameter int AF_LEVEL = 6
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic                     rd_valid,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     rd_err,
   input  logic                     clr_err,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic [$clog2(DEPTH):0]   count,
   output logic [63:0]              status
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   // Reject unsupported geometries at elaboration time
   if (!is_pow2_min2(DEPTH)) begin : g_bad_depth
      $error("mmio_fifo_buf: DEPTH must be a power of two and >= 2");
   end
   if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af_level
      $error("mmio_fifo_buf: AF_LEVEL must be in 1..DEPTH");
   end

   logic [AW-1:0]    wptr_reg;
   logic [AW-1:0]    rptr_reg;
   logic [CW-1:0]    count_reg;
   logic [CW-1:0]    count_next;
   logic             rd_valid_reg;
   logic             rd_err_reg;
   logic             rd_hit_reg;
   logic             ovf_reg;
   logic             udf_reg;
   logic [WIDTH-1:0] ram_rdata;
   logic [31:0]      stats_word;

   logic push_ok;
   logic pop_ok;
   logic drop;
   logic underflow;

   assign full        = (count_reg == CW'(DEPTH));
   assign empty       = (count_reg == '0);
   assign almost_full = (count_reg >= CW'(AF_LEVEL));
   assign count       = count_reg;

   // A pop on a full FIFO frees a slot, so a simultaneous push still lands
   assign pop_ok    = rd_en && !empty;
   assign push_ok   = wr_en && (!full || rd_en);
   assign drop      = wr_en && full && !rd_en;
   assign underflow = rd_en && empty;

   assign count_next = count_reg + CW'(push_ok) - CW'(pop_ok);

   mmio_fifo_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .we    (push_ok),
      .waddr (wptr_reg),
      .wdata (wr_data),
      .re    (pop_ok),
      .raddr (rptr_reg),
      .rdata (ram_rdata)
   );

   // Pointers, occupancy, pop response and sticky error flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_reg     <= '0;
         rptr_reg     <= '0;
         count_reg    <= '0;
         rd_valid_reg <= 1'b0;
         rd_err_reg   <= 1'b0;
         rd_hit_reg   <= 1'b0;
         ovf_reg      <= 1'b0;
         udf_reg      <= 1'b0;
      end else begin
         if (push_ok) begin
            wptr_reg <= wptr_reg + 1'b1;
         end
         if (pop_ok) begin
            rptr_reg <= rptr_reg + 1'b1;
         end
         count_reg    <= count_next;
         rd_valid_reg <= rd_en;
         rd_err_reg   <= underflow;
         rd_hit_reg   <= pop_ok;
         // A new error in the same cycle as clr_err keeps the flag set
         if (drop) begin
            ovf_reg <= 1'b1;
         end else if (clr_err) begin
            ovf_reg <= 1'b0;
         end
         if (underflow) begin
            udf_reg <= 1'b1;
         end else if (clr_err) begin
            udf_reg <= 1'b0;
         end
      end
   end

   assign rd_valid = rd_valid_reg;
   assign rd_err   = rd_err_reg;
   // Storage has no reset, so the word is forced to 0 unless the last pop hit
   assign rd_data  = rd_hit_reg ? ram_rdata : '0;

`ifdef MMIO_FIFO_STATS_EN
   logic [CW-1:0] hwm_reg;
   logic [15:0]   drops_reg;

   // High-water mark and saturating drop counter; clr_err always wins here
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hwm_reg   <= '0;
         drops_reg <= '0;
      end else if (clr_err) begin
         hwm_reg   <= '0;
         drops_reg <= '0;
      end else begin
         if (count_next > hwm_reg) begin
            hwm_reg <= count_next;
         end
         if (drop && (drops_reg != 16'hFFFF)) begin
            drops_reg <= drops_reg + 16'd1;
         end
      end
   end

   assign stats_word = {drops_reg, 16'(hwm_reg)};
`else
   assign stats_word = '0;
`endif

   // Status CSR image, decoded from registered state
   always_comb begin
      status                           = '0;
      status[ST_EMPTY]                 = empty;
      status[ST_FULL]                  = full;
      status[ST_UDF]                   = udf_reg;
      status[ST_OVF]                   = ovf_reg;
      status[ST_COUNT_LSB +: 16]       = 16'(count_reg);
      status[ST_HWM_LSB +: 32]         = stats_word;
   end

endmodule

// File: tb/tb_mmio_fifo_buf.sv
// Bench for mmio_fifo_buf: directed scenarios followed by random push/pop/clear
// traffic, all checked against a queue-based model of the FIFO.
// Honours MMIO_FIFO_STATS_EN for the expected upper status half.
module tb_mmio_fifo_buf;
   import mmio_fifo_pkg::*;

   localparam int WIDTH    = 64;
   localparam int DEPTH    = 8;
   localparam int AF_LEVEL = 6;
   localparam int CW       = $clog2(DEPTH) + 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              wr_en = 1'b0;
   logic [WIDTH-1:0]  wr_data = '0;
   logic              rd_en = 1'b0;
   logic              clr_err = 1'b0;
   logic              rd_valid;
   logic [WIDTH-1:0]  rd_data;
   logic              rd_err;
   logic              full;
   logic              empty;
   logic              almost_full;
   logic [CW-1:0]     count;
   logic [63:0]       status;

   always #5 clk = ~clk;

   mmio_fifo_buf #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .AF_LEVEL (AF_LEVEL)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .rd_en       (rd_en),
      .rd_valid    (rd_valid),
      .rd_data     (rd_data),
      .rd_err      (rd_err),
      .clr_err     (clr_err),
      .full        (full),
      .empty       (empty),
      .almost_full (almost_full),
      .count       (count),
      .status      (status)
   );

   // Reference model state
   logic [63:0] mq[$];
   bit          m_ovf;
   bit          m_udf;
   int          m_hwm;
   int          m_drops;
   logic [63:0] m_rdata;
   bit          m_rerr;

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] exp_status();
      logic [63:0] s;
      s = '0;
      s[0] = (mq.size() == 0);
      s[1] = (mq.size() == DEPTH);
      s[2] = m_udf;
      s[3] = m_ovf;
      s[31:16] = 16'(mq.size());
`ifdef MMIO_FIFO_STATS_EN
      s[47:32] = 16'(m_hwm);
      s[63:48] = 16'(m_drops);
`endif
      return s;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_ovf = 0;
      m_udf = 0;
      m_hwm = 0;
      m_drops = 0;
   endtask

   task automatic check_state(input string tag);
      check({tag, ".count"}, 64'(count), 64'(mq.size()));
      check({tag, ".full"}, 64'(full), 64'(mq.size() == DEPTH));
      check({tag, ".empty"}, 64'(empty), 64'(mq.size() == 0));
      check({tag, ".afull"}, 64'(almost_full), 64'(mq.size() >= AF_LEVEL));
      check({tag, ".status"}, status, exp_status());
   endtask

   // One clock of stimulus, then model update and comparison
   task automatic step(input string tag, input bit wr, input logic [63:0] wd,
                       input bit rd, input bit clr);
      wr_en = wr;
      wr_data = wd;
      rd_en = rd;
      clr_err = clr;
      @(posedge clk);
      #1;
      wr_en = 0;
      rd_en = 0;
      clr_err = 0;
      if (clr) begin
         m_ovf = 0;
         m_udf = 0;
         m_hwm = 0;
         m_drops = 0;
      end
      if (rd) begin
         if (mq.size() > 0) begin
            m_rdata = mq.pop_front();
            m_rerr = 0;
         end else begin
            m_rdata = '0;
            m_rerr = 1;
            m_udf = 1;
         end
      end
      if (wr) begin
         if (mq.size() < DEPTH) begin
            mq.push_back(wd);
         end else begin
            m_ovf = 1;
            if (!clr && m_drops < 65535) m_drops++;
         end
      end
      if (!clr && mq.size() > m_hwm) m_hwm = mq.size();
      check({tag, ".rd_valid"}, 64'(rd_valid), 64'(rd));
      if (rd) begin
         check({tag, ".rd_data"}, rd_data, m_rdata);
         check({tag, ".rd_err"}, 64'(rd_err), 64'(m_rerr));
      end
      check_state(tag);
   endtask

   initial begin
      bit          r_wr;
      bit          r_rd;
      bit          r_clr;
      logic [63:0] r_data;

      // Reset
      #2 rst_n = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("reset.rd_valid", 64'(rd_valid), 64'd0);
      check("reset.rd_data", rd_data, 64'd0);
      check("reset.rd_err", 64'(rd_err), 64'd0);
      check_state("reset");
      rst_n = 1'b1;

      // Fill then drain in order
      for (int i = 0; i < 8; i++) step("fill", 1, 64'hA0 + 64'(i), 0, 0);
      for (int i = 0; i < 8; i++) step("drain", 0, '0, 1, 0);

      // Pointer wrap
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 5; i++) step("wrap.push", 1, 64'h100 + 64'(i), 0, 0);
         for (int i = 0; i < 5; i++) step("wrap.pop", 0, '0, 1, 0);
      end

      // Overflow: dropped push, head is untouched, clr_err clears ovf
      for (int i = 0; i < 8; i++) step("ovf.fill", 1, 64'hA0 + 64'(i), 0, 0);
      step("ovf.drop", 1, 64'hDEAD, 0, 0);
      step("ovf.pop", 0, '0, 1, 0);
      step("ovf.clr", 0, '0, 0, 1);
      for (int i = 0; i < 7; i++) step("ovf.drain", 0, '0, 1, 0);

      // Underflow, then push+pop on empty (no bypass)
      step("udf.pop", 0, '0, 1, 0);
      step("udf.pushpop", 1, 64'h55, 1, 0);
      step("udf.pop55", 0, '0, 1, 0);
      step("udf.clr", 0, '0, 0, 1);

      // Push+pop while full, then reset mid-burst
      for (int i = 0; i < 8; i++) step("fullpp.fill", 1, 64'hB0 + 64'(i), 0, 0);
      step("fullpp.pushpop", 1, 64'h77, 1, 0);
      step("burst.pop", 0, '0, 1, 0);
      rd_en = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check("rst_mid.rd_valid", 64'(rd_valid), 64'd0);
      check_state("rst_mid");
      rd_en = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Statistics scenario (upper status half depends on the build)
      for (int i = 0; i < 7; i++) step("stats.push7", 1, 64'h200 + 64'(i), 0, 0);
      for (int i = 0; i < 3; i++) step("stats.pop3", 0, '0, 1, 0);
      for (int i = 0; i < 4; i++) step("stats.push4", 1, 64'h300 + 64'(i), 0, 0);
      step("stats.clr", 0, '0, 0, 1);
      for (int i = 0; i < 8; i++) step("stats.drain", 0, '0, 1, 0);

      // Random traffic, biased towards filling then towards draining
      for (int i = 0; i < 600; i++) begin
         if ((i / 100) % 2 == 0) begin
            r_wr = ($urandom_range(0, 3) != 0);
            r_rd = ($urandom_range(0, 3) == 0);
         end else begin
            r_wr = ($urandom_range(0, 3) == 0);
            r_rd = ($urandom_range(0, 3) != 0);
         end
         r_clr = ($urandom_range(0, 15) == 0);
         r_data = {$urandom, $urandom};
         step("rand", r_wr, r_data, r_rd, r_clr);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
